mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, fed by the datapath's register-file operands and decoded controller op. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results return to the datapath via MFHI/MFLO reads of `hi`/`lo`. The controller stalls any HI/LO-dependent instruction while `busy` or `start` is high.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for MULT/MULTU.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for DIV/DIVU.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset, asserted at 0.
- `start` input 1: issue strobe for the op on `mdOp`, valid for one cycle.
- `mdOp` input 3: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `A` input 32: operand rs; dividend for DIV/DIVU; write data for MTHI/MTLO.
- `B` input 32: operand rt; divisor for DIV/DIVU.
- `busy` output 1: registered; high while an operation is in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- **States:** IDLE and RUN. A down-counter `cnt` has width of at least clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.
- **IDLE, `start` = 1, `mdOp` in 1..4:**
  - Compute the result from `A`/`B` in the same cycle.
  - Latch it into internal pending registers `pHi`/`pLo`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - `hi`/`lo` are unchanged at this edge.
- **IDLE, `start` = 1, MTHI/MTLO:** write `A` into `hi`/`lo` at this edge. Stay IDLE; `busy` stays 0.
- **RUN:** decrement `cnt` each edge. On the edge where `cnt` equals 1: copy `pHi`/`pLo` into `hi`/`lo`, return to IDLE, and clear `busy`.
- **`start` while RUN:** ignored for every op, including MTHI/MTLO. The controller guarantees this never happens; the unit must not corrupt state if it does.
- **MULT:** signed 32x32 to 64; `hi` = [63:32], `lo` = [31:0]. **MULTU:** the same, unsigned.
- **DIV:** `lo` = quotient truncated toward zero; `hi` = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0.
- **DIVU:** unsigned quotient and remainder.
- **Divide by zero (DIV/DIVU with B = 0):** `busy` still runs DIV_CYCLES; on completion `hi` and `lo` keep their pre-issue values (`pHi`/`pLo` loaded from the current `hi`/`lo`). No exception.
- **NONE/reserved with `start` = 1:** no effect.

## Timing
- **Reset (`reset` = 0, asynchronous):** `busy` = 0, `hi` = 0, `lo` = 0, `cnt` = 0, `pHi`/`pLo` = 0, state IDLE. This takes effect immediately, without waiting for a clock edge.
- **Reset mid-operation:** the in-flight result is discarded and never written to `hi`/`lo`. The first rising edge after `reset` returns to 1 is a normal IDLE edge and accepts `start`.
- **Issue at edge k (N = MULT_CYCLES or DIV_CYCLES):**
  - `busy` = 1 in cycles k+1 through k+N.
  - `busy` = 0 from k+N+1.
  - New `hi`/`lo` are visible from cycle k+N+1.
- **Back-to-back ops:** `start` may be asserted in the first cycle where `busy` = 0. That edge both issues the op and leaves the completed `hi`/`lo` intact.
- **MTHI/MTLO latency:** the value is visible one cycle after the `start` edge.
- **Stall rule for the controller:** `start | busy`, combined with a HI/LO-using op in decode, means stall. The unit itself exposes only the registered `busy`.
- `hi`/`lo` change only at: MTHI/MTLO edges in IDLE, the RUN completion edge, or reset.

## Test plan
- **Reset, then MULT:** release reset, `start` MULT with A = 0xFFFFFFFE (−2), B = 3.
  - `busy` = 1 for exactly 5 cycles.
  - Then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA.
  - `hi`/`lo` read 0 throughout the busy window.
- **MULTU:** A = 0xFFFFFFFF, B = 0xFFFFFFFF, giving `hi` = 0xFFFFFFFE, `lo` = 0x00000001 after 5 cycles.
- **DIV:**
  - A = 0xFFFFFFF9 (−7), B = 2 gives `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF after 10 busy cycles.
  - DIV 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0.
- **DIVU by zero:** preload MTHI 0x11111111 and MTLO 0x22222222 (each visible next cycle, `busy` never rises). Then DIVU A = 5, B = 0: `busy` is high 10 cycles, and `hi`/`lo` remain 0x11111111 / 0x22222222.
- **Ignored starts:** during a MULT, pulse `start` with MTLO A = 0xDEADBEEF at busy cycle 2. `lo` must equal the MULT result, never 0xDEADBEEF, and `busy` must still fall after exactly 5 cycles.
- **Reset mid-op:** start DIVU 100/7, drop `reset` at busy cycle 4. `busy`, `hi` and `lo` go to 0 immediately (asynchronously). After release, `hi`/`lo` stay 0 with no late write. A new MULT issued in the first cycle after release completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue, held in pHi/pLo, and committed after the busy window.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC) + 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               busy_d;
    logic [31:0]        hi_d, lo_d, pHi, pLo, phi_d, plo_d;

    // Signed divide returning {remainder, quotient}; the one overflow case is pinned explicitly.
    function automatic logic [63:0] sdiv(input logic signed [31:0] n, input logic signed [31:0] d);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (n == 32'sh8000_0000 && d == -32'sd1) begin
            q = n;
            r = '0;
        end else if (d == '0) begin
            q = '0;
            r = '0;
        end else begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] udiv(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] q;
        logic [31:0] r;
        if (d == '0) begin
            q = '0;
            r = '0;
        end else begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    logic signed [63:0] a_ext, b_ext, prod_s;
    logic        [63:0] prod_u;

    assign a_ext  = $signed({{32{A[31]}}, A});
    assign b_ext  = $signed({{32{B[31]}}, B});
    assign prod_s = a_ext * b_ext;
    assign prod_u = {32'b0, A} * {32'b0, B};

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        busy_d  = busy;
        hi_d    = hi;
        lo_d    = lo;
        phi_d   = pHi;
        plo_d   = pLo;
        case (state)
            IDLE: begin
                if (start) begin
                    case (mdOp)
                        OP_MULT, OP_MULTU: begin
                            {phi_d, plo_d} = (mdOp == OP_MULT) ? prod_s : prod_u;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero commits the current HI/LO back unchanged.
                            if (B == '0) begin
                                phi_d = hi;
                                plo_d = lo;
                            end else if (mdOp == OP_DIV) begin
                                {phi_d, plo_d} = sdiv($signed(A), $signed(B));
                            end else begin
                                {phi_d, plo_d} = udiv(A, B);
                            end
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    hi_d    = pHi;
                    lo_d    = pLo;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            pHi   <= '0;
            pLo   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            busy  <= busy_d;
            hi    <= hi_d;
            lo    <= lo_d;
            pHi   <= phi_d;
            pLo   <= plo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: busy windows, HI/LO results, ignored starts, async reset.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdOp  (mdOp),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        mdOp  = op;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        mdOp  = 3'd0;
    endtask

    // Checks n busy cycles with HI/LO held, then the first idle cycle.
    task automatic busy_window(input string tag, input int n,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_hi_hold"}, hi, exp_hi);
            check({tag, "_lo_hold"}, lo, exp_lo);
            tick();
        end
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        mdOp  = 3'd0;
        A     = '0;
        B     = '0;
        #3;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        tick();
        tick();
        reset = 1'b1;

        // MULT -2 * 3
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        busy_window("mult", 5, 32'h0, 32'h0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU back-to-back in the first idle cycle
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        busy_window("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // DIV -7 / 2
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        busy_window("div", 10, 32'hFFFF_FFFE, 32'h0000_0001);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);

        // DIV overflow case
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_window("divovf", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("divovf_hi", hi, 32'h0);
        check("divovf_lo", lo, 32'h8000_0000);

        // DIVU
        issue(3'd4, 32'hFFFF_FFFF, 32'h10);
        busy_window("divu", 10, 32'h0, 32'h8000_0000);
        check("divu_hi", hi, 32'h0000_000F);
        check("divu_lo", lo, 32'h0FFF_FFFF);

        // MTHI / MTLO
        issue(3'd5, 32'h1111_1111, 32'h0);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_hi", hi, 32'h1111_1111);
        check("mthi_lo", lo, 32'h0FFF_FFFF);
        issue(3'd6, 32'h2222_2222, 32'h0);
        check("mtlo_busy", 32'(busy), 32'd0);
        check("mtlo_hi", hi, 32'h1111_1111);
        check("mtlo_lo", lo, 32'h2222_2222);

        // Reserved op does nothing
        issue(3'd7, 32'h3333_3333, 32'h4444_4444);
        check("rsvd_busy", 32'(busy), 32'd0);
        check("rsvd_hi", hi, 32'h1111_1111);
        check("rsvd_lo", lo, 32'h2222_2222);

        // DIVU by zero keeps HI/LO
        issue(3'd4, 32'd5, 32'd0);
        busy_window("divz", 10, 32'h1111_1111, 32'h2222_2222);
        check("divz_hi", hi, 32'h1111_1111);
        check("divz_lo", lo, 32'h2222_2222);

        // MULT 7*6 with an MTLO pulse in busy cycle 2
        issue(3'd1, 32'd7, 32'd6);
        check("ign_busy1", 32'(busy), 32'd1);
        tick();
        start = 1'b1;
        mdOp  = 3'd6;
        A     = 32'hDEAD_BEEF;
        check("ign_busy2", 32'(busy), 32'd1);
        tick();
        start = 1'b0;
        mdOp  = 3'd0;
        busy_window("ign", 3, 32'h1111_1111, 32'h2222_2222);
        check("ign_hi", hi, 32'h0);
        check("ign_lo", lo, 32'd42);

        // DIVU 100/7 interrupted by reset at busy cycle 4
        issue(3'd4, 32'd100, 32'd7);
        for (int i = 0; i < 3; i++) begin
            check("rst_pre_busy", 32'(busy), 32'd1);
            tick();
        end
        check("rst_c4_busy", 32'(busy), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_hi", hi, 32'h0);
        check("rst_async_lo", lo, 32'h0);
        tick();
        tick();
        check("rst_hold_busy", 32'(busy), 32'd0);
        check("rst_hold_lo", lo, 32'h0);
        reset = 1'b1;
        issue(3'd1, 32'hFFFF_FFFF, 32'h10);
        busy_window("postrst", 5, 32'h0, 32'h0);
        check("postrst_hi", hi, 32'hFFFF_FFFF);
        check("postrst_lo", lo, 32'hFFFF_FFF0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("late_hi", hi, 32'hFFFF_FFFF);
            check("late_lo", lo, 32'hFFFF_FFF0);
            check("late_busy", 32'(busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
